// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/shift/compare ops, iterative MULTU and
// optional iterative DIVU (compiled in when ALU_MC_DIV_EN is defined).
// Ports:
//   clk, rst (async, active low)
//   in_valid/in_ready, opcode, in_data_1 (A), in_data_2 (B / shift amount)
//   out_valid/out_ready, out_data (result/low product/quotient),
//   out_hi (high product/remainder), zero, overflow (ADD/SUB only)
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic [WIDTH-1:0] in_data_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             overflow
);

    localparam int LW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

    state_t state, state_nx;

    // Shared iterative datapath: hi = partial product / remainder,
    // lo = multiplier / quotient, opd = multiplicand / divisor.
    logic [WIDTH-1:0] hi, hi_nx;
    logic [WIDTH-1:0] lo, lo_nx;
    logic [WIDTH-1:0] opd, opd_nx;
    logic [LW:0]      cnt, cnt_nx;
    logic             fin, fin_nx;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] res_hi;
    logic             res_ovf;

    logic [WIDTH-1:0] s_data;
    logic             s_ovf;
    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;
    logic [LW-1:0]    sh;
    logic [WIDTH:0]   sum;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   rs;
    logic [WIDTH+1:0] df;
`endif

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign add_r = in_data_1 + in_data_2;
    assign sub_r = in_data_1 - in_data_2;
    assign sh    = in_data_2[LW-1:0];

    // Single-cycle result, taken straight from the inputs at the
    // accepting edge.
    always_comb begin
        s_data = '0;
        s_ovf  = 1'b0;
        unique case (opcode)
            OP_AND: s_data = in_data_1 & in_data_2;
            OP_OR:  s_data = in_data_1 | in_data_2;
            OP_XOR: s_data = in_data_1 ^ in_data_2;
            OP_NOR: s_data = ~(in_data_1 | in_data_2);
            OP_ADD: begin
                s_data = add_r;
                s_ovf  = (in_data_1[WIDTH-1] == in_data_2[WIDTH-1]) &&
                         (add_r[WIDTH-1] != in_data_1[WIDTH-1]);
            end
            OP_SUB: begin
                s_data = sub_r;
                s_ovf  = (in_data_1[WIDTH-1] != in_data_2[WIDTH-1]) &&
                         (sub_r[WIDTH-1] != in_data_1[WIDTH-1]);
            end
            OP_SLT: s_data = {{(WIDTH-1){1'b0}},
                              $signed(in_data_1) < $signed(in_data_2)};
            OP_SLTU: s_data = {{(WIDTH-1){1'b0}}, in_data_1 < in_data_2};
            OP_SLL: s_data = in_data_1 << sh;
            OP_SRL: s_data = in_data_1 >> sh;
            OP_SRA: s_data = WIDTH'($signed(in_data_1) >>> sh);
            default: s_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        hi_nx    = hi;
        lo_nx    = lo;
        opd_nx   = opd;
        cnt_nx   = cnt;
        fin_nx   = fin;
        load     = 1'b0;
        res_data = s_data;
        res_hi   = '0;
        res_ovf  = s_ovf;
        sum      = {1'b0, hi} + ({1'b0, opd} & {(WIDTH+1){lo[0]}});
`ifdef ALU_MC_DIV_EN
        rs       = {hi, lo[WIDTH-1]};
        df       = {1'b0, rs} - {2'b00, opd};
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_MULTU) begin
                        state_nx = MUL;
                        hi_nx    = '0;
                        lo_nx    = in_data_1;
                        opd_nx   = in_data_2;
                        cnt_nx   = (LW+1)'(WIDTH-1);
                        fin_nx   = 1'b0;
`ifdef ALU_MC_DIV_EN
                    end else if (opcode == OP_DIVU) begin
                        state_nx = DIV;
                        hi_nx    = '0;
                        lo_nx    = in_data_1;
                        opd_nx   = in_data_2;
                        cnt_nx   = (LW+1)'(WIDTH-1);
                        fin_nx   = 1'b0;
`endif
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            MUL: begin
                if (fin) begin
                    load     = 1'b1;
                    res_data = lo;
                    res_hi   = hi;
                    res_ovf  = 1'b0;
                    fin_nx   = 1'b0;
                    state_nx = IDLE;
                end else begin
                    // Add-then-shift: carry of the add enters hi's MSB.
                    {hi_nx, lo_nx} = {sum, lo[WIDTH-1:1]};
                    if (cnt == '0) fin_nx = 1'b1;
                    else           cnt_nx = cnt - 1'b1;
                end
            end
`ifdef ALU_MC_DIV_EN
            DIV: begin
                if (fin) begin
                    load     = 1'b1;
                    res_data = lo;
                    res_hi   = hi;
                    res_ovf  = 1'b0;
                    fin_nx   = 1'b0;
                    state_nx = IDLE;
                end else begin
                    // Divisor 0 always "fits", giving all-ones quotient
                    // and the dividend shifted through as remainder.
                    if (!df[WIDTH+1]) begin
                        hi_nx = df[WIDTH-1:0];
                        lo_nx = {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_nx = rs[WIDTH-1:0];
                        lo_nx = {lo[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == '0) fin_nx = 1'b1;
                    else           cnt_nx = cnt - 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi  <= '0;
            lo  <= '0;
            opd <= '0;
            cnt <= '0;
            fin <= 1'b0;
        end else begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            opd <= opd_nx;
            cnt <= cnt_nx;
            fin <= fin_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_hi    <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_hi    <= res_hi;
            zero      <= (res_data == '0);
            overflow  <= res_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH = 32).
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [31:0] in_data_1;
    logic [31:0] in_data_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_hi;
    logic        zero;
    logic        overflow;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_hi    (out_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [31:0] h;
        logic        z;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: compares every result the consumer takes.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got d=%h h=%h, expected none",
                         out_data, out_hi);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.d || out_hi !== e.h ||
                    zero !== e.z || overflow !== e.v) begin
                    errors++;
                    $display("FAIL %s: got d=%h h=%h z=%b v=%b, expected d=%h h=%h z=%b v=%b",
                             e.name, out_data, out_hi, zero, overflow,
                             e.d, e.h, e.z, e.v);
                end
            end
        end
    end

    // Issues one op (called at posedge+1). Returns at accept edge + 1.
    task automatic send(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] ed,
                        input logic [31:0] eh, input logic ez,
                        input logic ev, output time t_acc);
        exp_t e;
        int n;
        in_valid  = 1'b1;
        opcode    = op;
        in_data_1 = a;
        in_data_2 = b;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        t_acc = 0;
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 1'b0, 32'(n), 32'd60);
            in_valid = 1'b0;
        end else begin
            if (push) begin
                e.name = name; e.d = ed; e.h = eh; e.z = ez; e.v = ev;
                sb.push_back(e);
            end
            @(posedge clk);
            t_acc = $time;
            #1;
            in_valid  = 1'b0;
            // Scramble inputs: captured values must not change.
            opcode    = 4'($urandom);
            in_data_1 = $urandom;
            in_data_2 = $urandom;
        end
    endtask

    task automatic multi_wait(input string name, input int lat);
        int i;
        bit quiet;
        quiet = 1'b1;
        i = 0;
        check({name, "_busy_ready"}, in_ready == 1'b0, 32'(in_ready), 32'd0);
        while (i < 60) begin
            @(posedge clk);
            #1;
            i++;
            if (out_valid) break;
            if (in_ready) quiet = 1'b0;
        end
        check({name, "_latency"}, i == lat, 32'(i), 32'(lat));
        check({name, "_in_ready_low"}, quiet, 32'(quiet), 32'd1);
    endtask

    initial begin
        time t0, t1, t2;
        int n;
        bit stable;
        rst       = 1'b0;
        in_valid  = 1'b0;
        opcode    = 4'h0;
        in_data_1 = '0;
        in_data_2 = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid == 1'b0, 32'(out_valid), 32'd0);
        check("rst_out_data", out_data == 32'h0, out_data, 32'h0);
        check("rst_zero", zero == 1'b1, 32'(zero), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready == 1'b1, 32'(in_ready), 32'd1);

        send("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 1,
             32'h80000000, 32'h0, 1'b0, 1'b1, t0);
        check("add_latency", out_valid == 1'b1, 32'(out_valid), 32'd1);

        send("sub_zero", 4'b0110, 32'd5, 32'd5, 1, 32'h0, 32'h0, 1'b1, 1'b0, t0);
        send("slt", 4'b0111, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 32'h0, 1'b0, 1'b0, t1);
        send("sltu", 4'b1011, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 32'h0, 1'b1, 1'b0, t2);
        check("b2b_throughput", (t1 - t0 == 10) && (t2 - t1 == 10),
              32'(t2 - t0), 32'd20);

        send("sra", 4'b1010, 32'h80000000, 32'd4, 1,
             32'hF8000000, 32'h0, 1'b0, 1'b0, t0);
        send("sll_mask", 4'b1000, 32'h1, 32'h3F, 1,
             32'h80000000, 32'h0, 1'b0, 1'b0, t0);
        send("srl", 4'b1001, 32'h80000000, 32'd31, 1, 32'h1, 32'h0, 1'b0, 1'b0, t0);
        send("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 1,
             32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, t0);
        send("and", 4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, 1,
             32'hF000_1200, 32'h0, 1'b0, 1'b0, t0);
        send("or", 4'b0001, 32'hF0F0_0000, 32'h0000_00FF, 1,
             32'hF0F0_00FF, 32'h0, 1'b0, 1'b0, t0);
        send("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 1,
             32'h5555_5555, 32'h0, 1'b0, 1'b0, t0);
        send("nor", 4'b0100, 32'hFFFF_0000, 32'h0000_FF00, 1,
             32'h0000_00FF, 32'h0, 1'b0, 1'b0, t0);
        send("unused_op", 4'b1111, 32'h1234, 32'h5678, 1,
             32'h0, 32'h0, 1'b1, 1'b0, t0);

        send("multu_max", 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,
             32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, t0);
        multi_wait("multu_max", 33);
        send("multu_small", 4'b1100, 32'd3, 32'd5, 1,
             32'd15, 32'h0, 1'b0, 1'b0, t0);
        multi_wait("multu_small", 33);

`ifdef ALU_MC_DIV_EN
        send("divu", 4'b1101, 32'd100, 32'd7, 1, 32'd14, 32'd2, 1'b0, 1'b0, t0);
        multi_wait("divu", 33);
        send("divu_by0", 4'b1101, 32'd9, 32'd0, 1,
             32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, t0);
        multi_wait("divu_by0", 33);
`else
        send("divu_off", 4'b1101, 32'd100, 32'd7, 1, 32'h0, 32'h0, 1'b1, 1'b0, t0);
        check("divu_off_latency", out_valid == 1'b1, 32'(out_valid), 32'd1);
`endif
        @(posedge clk);
        #1;

        // Back-pressure hold.
        out_ready = 1'b0;
        send("add_hold", 4'b0010, 32'd3, 32'd4, 1, 32'd7, 32'h0, 1'b0, 1'b0, t0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!(out_valid && out_data == 32'd7 && !in_ready)) stable = 1'b0;
        end
        check("hold_stable", stable, out_data, 32'd7);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release", out_valid == 1'b0, 32'(out_valid), 32'd0);

        // Reset in the middle of a multiply.
        send("multu_abort", 4'b1100, 32'h1234, 32'h5678, 0,
             32'h0, 32'h0, 1'b0, 1'b0, t0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid == 1'b0, 32'(out_valid), 32'd0);
        check("abort_out_data", out_data == 32'h0, out_data, 32'h0);
        check("abort_out_hi", out_hi == 32'h0, out_hi, 32'h0);
        check("abort_zero", zero == 1'b1, 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stable = 1'b0;
        end
        check("abort_no_stale", stable, 32'(stable), 32'd1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_empty", sb.size() == 0, 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
